hyperterm_tx: RTL and testbench

- UART transmit side of the COM interface: sends 16-bit words from the CPU/debug side to the host terminal on the TX line.
- Pairs with the existing receive-side hyperterm loader, which carries the program image into command memory.
- Used for program readback and debug output.
- Each word is sent as two 8N1 (optionally 8E1) bytes, high byte first, with host RTS flow control at byte boundaries.

---
 rtl/hyperterm_tx.sv | 125 ++++++++++++
 tb/tb_hyperterm_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperterm_tx.sv
// UART transmitter for the COM interface: sends 16-bit words as two 8N1/8E1
// bytes (high byte first), gated by host RTS at byte boundaries.
module hyperterm_tx #(
    parameter int unsigned CLK_DIV   = 417,
    parameter bit          PARITY_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_s,
    input  logic [15:0] data,
    input  logic        wren,
    output logic        ready,
    output logic        busy,
    input  logic        rts,
    output logic        tx,
    output logic [15:0] words_sent
);
    localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [15:0]   word_buf;
    logic          byte_sel;
    logic          pending;
    logic          rts_meta, rts_s;
    logic          bit_done;
    logic          start_go;

    assign ready    = ~pending;
    assign busy     = pending;
    assign bit_done = (cnt == CW'(CLK_DIV - 1));
    assign start_go = pending && rts_s;

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            rts_meta <= 1'b0;
            rts_s    <= 1'b0;
        end else begin
            rts_meta <= rts;
            rts_s    <= rts_meta;
        end
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_go) state_nx = START;
            START:   if (bit_done) state_nx = DATA;
            DATA:    if (bit_done && bit_cnt == 3'd7) state_nx = PARITY_EN ? PARITY : STOP;
            PARITY:  if (bit_done) state_nx = STOP;
            STOP:    if (bit_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            word_buf   <= '0;
            byte_sel   <= 1'b0;
            pending    <= 1'b0;
            tx         <= 1'b1;
            words_sent <= '0;
        end else begin
            // baud counter restarts on every state change and is parked in IDLE
            if (state_nx != state || state == IDLE) cnt <= '0;
            else                                    cnt <= cnt + 1'b1;

            if (wren && !pending) begin
                word_buf <= data;
                byte_sel <= 1'b0;
                pending  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_go) begin
                        shreg <= byte_sel ? word_buf[7:0] : word_buf[15:8];
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == 3'd7) begin
                            tx <= PARITY_EN ? ^shreg : 1'b1;
                        end else begin
                            tx      <= shreg[bit_cnt + 3'd1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) tx <= 1'b1;
                end
                STOP: begin
                    if (bit_done) begin
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                        end else begin
                            pending    <= 1'b0;
                            words_sent <= words_sent + 16'd1;
                        end
                    end
                end
                default: tx <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_hyperterm_tx.sv
// Bench for hyperterm_tx: directed words push expected bytes into queues, a
// serial-line monitor decodes tx frames and compares against them.
module tb_hyperterm_tx;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_s;
    logic [15:0] data [2];
    logic        wren [2];
    logic        ready [2];
    logic        busy [2];
    logic        rts [2];
    logic        tx [2];
    logic [15:0] words_sent [2];

    int n_cmp = 0;
    int n_bad = 0;

    // expected {parity, byte} per instance; parity ignored for instance 0
    logic [8:0] exp_q0 [$];
    logic [8:0] exp_q1 [$];

    always #5 clk = ~clk;

    hyperterm_tx #(.CLK_DIV(DIV), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst_s(rst_s), .data(data[0]), .wren(wren[0]), .ready(ready[0]),
        .busy(busy[0]), .rts(rts[0]), .tx(tx[0]), .words_sent(words_sent[0])
    );

    hyperterm_tx #(.CLK_DIV(DIV), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst_s(rst_s), .data(data[1]), .wren(wren[1]), .ready(ready[1]),
        .busy(busy[1]), .rts(rts[1]), .tx(tx[1]), .words_sent(words_sent[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // serial monitor: samples each bit at its centre, aborts on reset
    int         rx_cnt [2];
    logic       rx_act [2] = '{1'b0, 1'b0};
    logic [7:0] rx_byte [2];
    logic       rx_par;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_s) begin
                rx_act[i] = 1'b0;
            end else if (!rx_act[i]) begin
                if (tx[i] == 1'b0) begin
                    rx_act[i] = 1'b1;
                    rx_cnt[i] = 0;
                end
            end else begin
                rx_cnt[i]++;
                if (rx_cnt[i] % DIV == DIV / 2) begin
                    int bi;
                    bi = rx_cnt[i] / DIV;
                    if (bi == 0) begin
                        check($sformatf("start_bit%0d", i), 32'(tx[i]), 32'd0);
                    end else if (bi <= 8) begin
                        rx_byte[i][bi-1] = tx[i];
                    end else if (i == 1 && bi == 9) begin
                        rx_par = tx[1];
                    end else if (bi == 9 + i) begin
                        logic [8:0] e;
                        logic       have;
                        have = 1'b1;
                        e    = '0;
                        if (i == 0) begin
                            if (exp_q0.size() == 0) have = 1'b0;
                            else e = exp_q0.pop_front();
                        end else begin
                            if (exp_q1.size() == 0) have = 1'b0;
                            else e = exp_q1.pop_front();
                        end
                        if (!have) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_byte%0d: got %0h expected none", i, rx_byte[i]);
                        end else begin
                            check($sformatf("byte%0d", i), 32'(rx_byte[i]), 32'(e[7:0]));
                            if (i == 1) check("parity1", 32'(rx_par), 32'(e[8]));
                        end
                        check($sformatf("stop_bit%0d", i), 32'(tx[i]), 32'd1);
                        rx_act[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drive one accept edge; returns just after it
    task automatic write_word(input int i, input logic [15:0] d);
        data[i] = d;
        wren[i] = 1'b1;
        @(posedge clk);
        #1;
        wren[i] = 1'b0;
    endtask

    task automatic wait_ready(input int i, output int cyc);
        cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (ready[i]) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int  cyc;
        logic bad;
        rst_s = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data[i] = '0;
            wren[i] = 1'b0;
            rts[i]  = 1'b0;
        end
        step(3);
        check("rst_tx", 32'(tx[0]), 32'd1);
        check("rst_ready", 32'(ready[0]), 32'd1);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_words", 32'(words_sent[0]), 32'd0);
        rst_s  = 1'b0;
        rts[0] = 1'b1;
        rts[1] = 1'b1;
        step(3);

        // 1: plain 8N1 word, high byte first
        exp_q0.push_back(9'h0A5);
        exp_q0.push_back(9'h05A);
        write_word(0, 16'hA55A);
        check("busy_after_accept", 32'(busy[0]), 32'd1);
        wait_ready(0, cyc);
        check("latency_8n1", 32'(cyc), 32'd82);
        check("words_1", 32'(words_sent[0]), 32'd1);

        // 2: 8E1 word
        exp_q1.push_back(9'h107);
        exp_q1.push_back(9'h101);
        write_word(1, 16'h0701);
        wait_ready(1, cyc);
        check("latency_8e1", 32'(cyc), 32'd90);
        check("words_p1", 32'(words_sent[1]), 32'd1);

        // 3: word held off by rts until it rises
        rts[0] = 1'b0;
        step(3);
        exp_q0.push_back(9'h012);
        exp_q0.push_back(9'h034);
        write_word(0, 16'h1234);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (tx[0] !== 1'b1 || busy[0] !== 1'b1) bad = 1'b1;
            step(1);
        end
        check("rts_hold", 32'(bad), 32'd0);
        rts[0] = 1'b1;
        cyc = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (tx[0] == 1'b0) begin
                cyc = c;
                break;
            end
        end
        check("rts_start_delay", 32'(cyc), 32'd3);
        wait_ready(0, cyc);
        check("words_2", 32'(words_sent[0]), 32'd2);

        // 4: rts drops mid high byte
        exp_q0.push_back(9'h0FF);
        exp_q0.push_back(9'h0FF);
        write_word(0, 16'hFFFF);
        step(12);
        rts[0] = 1'b0;
        step(40);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (tx[0] !== 1'b1 || busy[0] !== 1'b1) bad = 1'b1;
            step(1);
        end
        check("gap_hold", 32'(bad), 32'd0);
        check("high_byte_done", 32'(exp_q0.size()), 32'd1);
        rts[0] = 1'b1;
        wait_ready(0, cyc);
        check("words_3", 32'(words_sent[0]), 32'd3);

        // 5: write while busy is ignored, then counter wrap
        exp_q0.push_back(9'h013);
        exp_q0.push_back(9'h057);
        write_word(0, 16'h1357);
        step(5);
        write_word(0, 16'hBEEF);
        wait_ready(0, cyc);
        check("busy_write_ready", 32'(cyc > 0), 32'd1);
        step(3);
        check("busy_write_q", 32'(exp_q0.size()), 32'd0);
        check("words_4", 32'(words_sent[0]), 32'd4);
        force dut0.words_sent = 16'hFFFF;
        #1;
        release dut0.words_sent;
        step(1);
        exp_q0.push_back(9'h00F);
        exp_q0.push_back(9'h00F);
        write_word(0, 16'h0F0F);
        wait_ready(0, cyc);
        check("words_wrap", 32'(words_sent[0]), 32'd0);

        // 6: reset mid-data while tx is low
        write_word(0, 16'h3C3C);
        step(9);
        #2;
        check("pre_rst_tx", 32'(tx[0]), 32'd0);
        rst_s = 1'b1;
        #1;
        check("async_rst_tx", 32'(tx[0]), 32'd1);
        check("async_rst_ready", 32'(ready[0]), 32'd1);
        check("async_rst_words", 32'(words_sent[0]), 32'd0);
        exp_q0.delete();
        step(2);
        rst_s = 1'b0;
        step(3);
        exp_q0.push_back(9'h000);
        exp_q0.push_back(9'h0FF);
        write_word(0, 16'h00FF);
        wait_ready(0, cyc);
        check("latency_post_rst", 32'(cyc), 32'd82);
        check("words_post_rst", 32'(words_sent[0]), 32'd1);

        step(20);
        check("q0_drained", 32'(exp_q0.size()), 32'd0);
        check("q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
